// File: rtl/i2c_pkg.sv
// Shared types and timing helpers for the I2C register-update master.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BYTE,
      ST_ACK,
      ST_STOP,
      ST_GAP
   } i2c_state_e;

   localparam int NUM_REGS    = 4;
   localparam int FRAME_BYTES = 5;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   function automatic int quarter_cycles(input int clk_hz, input int i2c_hz);
      return clk_hz / (4 * i2c_hz);
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit tick generator: Q-cycle counter plus a wrapping 2-bit quarter phase.
module i2c_tick_gen #(
   parameter int Q = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       restart,
   output logic       tick,
   output logic       pre_tick,
   output logic [1:0] phase
);

   localparam int CW = (Q > 2) ? $clog2(Q) : 1;
   localparam logic [CW-1:0] LAST = CW'(Q - 1);
   localparam logic [CW-1:0] PRE  = CW'(Q - 2);

   generate
      if (Q < 2) begin : g_bad_q
         $error("i2c_tick_gen: quarter period must be at least 2 cycles");
      end
   endgenerate

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    phase_q, phase_d;

   always_comb begin
      tick     = (cnt_q == LAST);
      pre_tick = (cnt_q == PRE);
      cnt_d    = cnt_q + CW'(1);
      phase_d  = phase_q;
      if (restart) begin
         cnt_d   = '0;
         phase_d = 2'd0;
      end else if (tick) begin
         cnt_d   = '0;
         phase_d = phase_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         phase_q <= 2'd0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/i2c_reg_update_master.sv
// I2C master writing {addr+W, y0, y1, speed, trig} as one frame, with one queued request.
module i2c_reg_update_master
   import i2c_pkg::*;
#(
   parameter int         CLK_HZ     = 100_000_000,
   parameter int         I2C_HZ     = 100_000,
   parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] y0_in,
   input  logic [7:0] y1_in,
   input  logic [7:0] speed_in,
   input  logic [7:0] trig_in,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       SCL,
   inout  wire        SDA
);

   localparam int Q = quarter_cycles(CLK_HZ, I2C_HZ);

   i2c_state_e                  state_q, state_d;
   logic [2:0]                  byte_cnt_q, byte_cnt_d;
   logic [2:0]                  bit_cnt_q, bit_cnt_d;
   logic [NUM_REGS-1:0][7:0]    shadow_q, shadow_d;
   logic pending_q, pending_d, busy_q, busy_d, done_q, done_d;
   logic ack_err_q, ack_err_d, nack_q, nack_d, scl_q, scl_d, sda_oe_q, sda_oe_d;
   logic       launch, reload, tick, pre_tick;
   logic [1:0] phase, next_phase;
   logic [7:0] tx_byte;

   // Returns {scl, sda_pull_low} for a given state, quarter and data bit.
   function automatic logic [1:0] bus_drive(input i2c_state_e st, input logic [1:0] ph,
                                            input logic bit_v);
      logic [1:0] r;
      r = 2'b10;
      case (st)
         ST_START: r = {1'b1, ph >= Q2};
         ST_BYTE:  r = {ph >= Q2, ~bit_v};
         ST_ACK:   r = {ph >= Q2, 1'b0};
         ST_STOP:  r = {ph != Q0, ph <= Q1};
         default:  r = 2'b10;
      endcase
      return r;
   endfunction

   i2c_tick_gen #(.Q(Q)) u_tick (
      .clk      (clk),
      .rst_n    (reset),
      .restart  (launch),
      .tick     (tick),
      .pre_tick (pre_tick),
      .phase    (phase)
   );

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shadow_d   = shadow_q;
      pending_d  = pending_q;
      busy_d     = busy_q;
      ack_err_d  = ack_err_q;
      nack_d     = nack_q;
      scl_d      = scl_q;
      sda_oe_d   = sda_oe_q;
      launch     = 1'b0;
      reload     = 1'b0;
      next_phase = phase + 2'd1;
      if (start && busy_q) pending_d = 1'b1;
      if (state_q == ST_IDLE) begin
         launch = start || pending_q;
      end else if (tick) begin
         case (state_q)
            ST_START: if (phase == Q3) begin
               state_d    = ST_BYTE;
               byte_cnt_d = 3'd0;
               bit_cnt_d  = 3'd7;
            end
            ST_BYTE: if (phase == Q3) begin
               if (bit_cnt_q == 3'd0) state_d = ST_ACK;
               else bit_cnt_d = bit_cnt_q - 3'd1;
            end
            ST_ACK: begin
               if (phase == Q2) begin
                  nack_d    = SDA;
                  ack_err_d = ack_err_q | SDA;
               end
               if (phase == Q3) begin
                  if (nack_q || byte_cnt_q == 3'(FRAME_BYTES - 1)) begin
                     state_d = ST_STOP;
                  end else begin
                     state_d    = ST_BYTE;
                     byte_cnt_d = byte_cnt_q + 3'd1;
                     bit_cnt_d  = 3'd7;
                  end
               end
            end
            ST_STOP: if (phase == Q3) state_d = ST_GAP;
            ST_GAP: if (phase == Q3) begin
               if (pending_q) begin
                  reload = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      if (launch) begin
         busy_d     = 1'b1;
         next_phase = Q0;
      end
      // A queued request that meets its consumption cycle is absorbed here.
      if (launch || reload) begin
         state_d   = ST_START;
         shadow_d  = {trig_in, speed_in, y1_in, y0_in};
         ack_err_d = 1'b0;
         pending_d = 1'b0;
      end
      done_d  = (state_q == ST_GAP) && (phase == Q3) && pre_tick;
      tx_byte = (byte_cnt_d == 3'd0) ? {SLAVE_ADDR, 1'b0} : shadow_d[2'(byte_cnt_d - 3'd1)];
      // Bus pins move only on quarter boundaries, already aligned to the new quarter.
      if (launch || (tick && state_q != ST_IDLE)) begin
         {scl_d, sda_oe_d} = bus_drive(state_d, next_phase, tx_byte[bit_cnt_d]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 3'd0;
         bit_cnt_q  <= 3'd0;
         shadow_q   <= '0;
         pending_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         nack_q     <= 1'b0;
         scl_q      <= 1'b1;
         sda_oe_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ack_err_q  <= ack_err_d;
         nack_q     <= nack_d;
         scl_q      <= scl_d;
         sda_oe_q   <= sda_oe_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign ack_err = ack_err_q;
   assign SCL     = scl_q;
   assign SDA     = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_update_master.sv
// Directed bench: behavioural I2C slave with byte scoreboard, timing and bus-shape checks.
module tb_i2c_reg_update_master;

   localparam int CLK_HZ = 4_000_000;
   localparam int I2C_HZ = 100_000;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] y0 = '0, y1 = '0, spd = '0, trg = '0;
   wire        busy, done, ack_err, scl;
   wire        sda_bus;
   logic       slv_drive = 1'b0;
   logic       slv_ack_en = 1'b1;

   pullup (sda_bus);
   assign sda_bus = slv_drive ? 1'b0 : 1'bz;

   i2c_reg_update_master #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .SLAVE_ADDR(7'h2A)) dut (
      .clk      (clk),
      .reset    (reset_n),
      .start    (start),
      .y0_in    (y0),
      .y1_in    (y1),
      .speed_in (spd),
      .trig_in  (trg),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .SCL      (scl),
      .SDA      (sda_bus)
   );

   // clock
   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // behavioural slave + bus monitor, sampled mid-cycle
   logic prev_scl = 1'b1, prev_sda = 1'b1, s_scl, s_sda;
   logic in_frame = 1'b0, ack_phase = 1'b0;
   logic [7:0] shreg = '0;
   logic [7:0] exp_b;
   int bitn = 0, run_len = 0, hi20 = 0, lo20 = 0, lo10 = 0, starts = 0, stops = 0;

   always @(negedge clk) begin
      s_scl = scl;
      s_sda = (sda_bus !== 1'b0);
      if (s_scl == prev_scl) begin
         run_len++;
      end else begin
         if (prev_scl && run_len == 20) hi20++;
         if (!prev_scl && run_len == 20) lo20++;
         if (!prev_scl && run_len == 10) lo10++;
         run_len = 1;
      end
      if (prev_scl && s_scl && prev_sda && !s_sda) begin
         starts++; in_frame = 1'b1; bitn = 0; ack_phase = 1'b0;
      end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
         stops++; in_frame = 1'b0; slv_drive = 1'b0; ack_phase = 1'b0;
      end else if (in_frame && !prev_scl && s_scl && !ack_phase && bitn < 8) begin
         shreg = {shreg[6:0], s_sda};
         bitn++;
         if (bitn == 8) begin
            check("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_b = exp_q.pop_front();
               check("bus_byte", 32'(shreg), 32'(exp_b));
            end
         end
      end else if (in_frame && prev_scl && !s_scl) begin
         if (ack_phase) begin
            slv_drive = 1'b0; ack_phase = 1'b0; bitn = 0;
         end else if (bitn == 8) begin
            ack_phase = 1'b1; slv_drive = slv_ack_en;
         end
      end
      prev_scl = s_scl;
      prev_sda = s_sda;
   end

   task automatic push_frame(input logic [7:0] a, b, c, d);
      exp_q.push_back(8'h54);
      exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
   endtask

   task automatic launch(input logic [7:0] a, b, c, d);
      @(negedge clk);
      y0 = a; y1 = b; spd = c; trg = d;
      start = 1'b1;
   endtask

   // Counts cycles after the launch cycle until done; toggles inputs when asked.
   task automatic wait_done(input int maxc, input bit toggle, output int n, output int busy_lo);
      n = 0; busy_lo = 0;
      while (n <= maxc) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (!busy) busy_lo++;
         if (done) break;
         if (toggle) begin
            y0 = 8'($urandom_range(0, 255)); y1 = 8'($urandom_range(0, 255));
            spd = 8'($urandom_range(0, 255)); trg = 8'($urandom_range(0, 255));
         end
      end
   endtask

   int n, blo, dn, n2, st0, sp0;

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      check("rst_scl", 32'(scl), 32'd1);
      check("rst_sda", 32'(sda_bus === 1'b1), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ack_err", 32'(ack_err), 32'd0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // normal write
      hi20 = 0; lo20 = 0; lo10 = 0; starts = 0; stops = 0;
      push_frame(8'h40, 8'hA0, 8'h03, 8'h01);
      launch(8'h40, 8'hA0, 8'h03, 8'h01);
      wait_done(2500, 1'b0, n, blo);
      check("norm_done_latency", 32'(n), 32'd1920);
      check("norm_busy_held", 32'(blo), 32'd0);
      check("norm_ack_err", 32'(ack_err), 32'd0);
      @(negedge clk);
      check("norm_busy_drop", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      check("norm_sb_empty", 32'(exp_q.size()), 32'd0);
      check("norm_scl_high20", 32'(hi20), 32'd45);
      check("norm_scl_low20", 32'(lo20), 32'd45);
      check("norm_stop_low10", 32'(lo10), 32'd1);
      check("norm_starts", 32'(starts), 32'd1);
      check("norm_stops", 32'(stops), 32'd1);

      // address NACK
      slv_ack_en = 1'b0;
      st0 = starts; sp0 = stops;
      exp_q.push_back(8'h54);
      launch(8'h99, 8'h88, 8'h77, 8'h66);
      wait_done(1000, 1'b0, n, blo);
      check("nack_done_latency", 32'(n), 32'd480);
      check("nack_ack_err", 32'(ack_err), 32'd1);
      repeat (100) @(negedge clk);
      check("nack_ack_err_sticky", 32'(ack_err), 32'd1);
      check("nack_idle", 32'(busy), 32'd0);
      check("nack_one_start", 32'(starts - st0), 32'd1);
      check("nack_one_stop", 32'(stops - sp0), 32'd1);
      check("nack_sb_empty", 32'(exp_q.size()), 32'd0);
      slv_ack_en = 1'b1;

      // queued update: three starts mid-frame collapse into one extra frame
      push_frame(8'h5A, 8'hA5, 8'hC3, 8'h3C);
      launch(8'h5A, 8'hA5, 8'hC3, 8'h3C);
      @(negedge clk);
      start = 1'b0;
      check("relaunch_ack_err_clr", 32'(ack_err), 32'd0);
      dn = 0; blo = 0; n2 = 0;
      for (int c = 2; c <= 5000; c++) begin
         @(negedge clk);
         start = (c == 200 || c == 700 || c == 1200);
         if (c == 1500) begin
            y0 = 8'h11; y1 = 8'h22; spd = 8'h33; trg = 8'h44;
            push_frame(8'h11, 8'h22, 8'h33, 8'h44);
         end
         if (!busy) blo++;
         if (done) dn++;
         if (dn == 2) begin
            n2 = c;
            break;
         end
      end
      start = 1'b0;
      check("queue_second_done", 32'(n2), 32'd3840);
      check("queue_busy_never_low", 32'(blo), 32'd0);
      dn = 0;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         if (done) dn++;
      end
      check("queue_no_third_frame", 32'(dn), 32'd0);
      check("queue_idle", 32'(busy), 32'd0);
      check("queue_sb_empty", 32'(exp_q.size()), 32'd0);

      // snapshot hold while inputs churn
      push_frame(8'h12, 8'h34, 8'h56, 8'h78);
      launch(8'h12, 8'h34, 8'h56, 8'h78);
      wait_done(2500, 1'b1, n, blo);
      check("snap_done_latency", 32'(n), 32'd1920);
      repeat (20) @(negedge clk);
      check("snap_sb_empty", 32'(exp_q.size()), 32'd0);

      // async reset in the middle of the y0 byte, SCL low
      exp_q.push_back(8'h54);
      launch(8'hF0, 8'h0F, 8'hAA, 8'h55);
      @(negedge clk);
      start = 1'b0;
      repeat (484) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("arst_scl", 32'(scl), 32'd1);
      check("arst_sda", 32'(sda_bus === 1'b1), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("arst_sb_empty", 32'(exp_q.size()), 32'd0);
      push_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      launch(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      wait_done(2500, 1'b0, n, blo);
      check("arst_clean_latency", 32'(n), 32'd1920);
      check("arst_clean_ack_err", 32'(ack_err), 32'd0);
      repeat (20) @(negedge clk);
      check("arst_clean_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_reg_update_master.md
Name: i2c_reg_update_master

Overview:
- Board-side I2C master that pushes the four game/video control bytes (paddle y0, paddle y1, ball speed, trigger) into the remote I2C slave register file as one write frame.
- Each frame carries slave address plus write bit, then four data bytes. The slave maps data byte n to slv_reg n (0..3).
- Sequences the whole bus transaction: START, bytes, ACK checks, STOP, bus-free gap. Also queues one update request that arrives while a frame is in progress.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- I2C_HZ, 100_000, SCL frequency.
- SLAVE_ADDR, 7'h2A, 7-bit target address.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle update request
- y0_in  input  8  value for slv_reg0
- y1_in  input  8  value for slv_reg1
- speed_in  input  8  value for slv_reg2
- trig_in  input  8  value for slv_reg3
- busy  output  1  frame in progress, including bus-free gap
- done  output  1  one-cycle pulse at end of every frame
- ack_err  output  1  sticky NACK flag for the last frame
- SCL  output  1  push-pull I2C clock; no clock stretching
- SDA  inout  1  open-drain: drives 0 or releases to Z

Behaviour:
- Reset (reset=0, async) forces: SCL=1, SDA=Z, busy=0, done=0, ack_err=0, pending=0, FSM to IDLE. Reset mid-frame aborts the frame immediately with no STOP; the slave resynchronises on the next START.
- Tick timing:
  - Q = CLK_HZ/(4*I2C_HZ) cycles per quarter-bit. Q<2 is an elaboration error.
  - A free-running tick counter restarts at frame launch.
- FSM states: IDLE, START, BYTE, ACK, STOP, GAP.
- Launch:
  - In IDLE, start=1 snapshots the 4 input bytes into shadow registers and clears ack_err.
  - busy=1 from the next cycle.
  - Inputs changing after the snapshot do not affect the frame.
- START (4 quarters): Q0-1 SCL=1, SDA=Z; Q2-3 SCL=1, SDA=0.
- BYTE (8 bits, MSB first, 4 quarters per bit):
  - Q0: SCL=0, SDA updated.
  - Q1: SCL=0.
  - Q2-3: SCL=1.
  - SDA only changes while SCL=0.
- ACK bit: master releases SDA; samples SDA on the last clk of Q2.
  - 0 (ACK): next byte, or STOP after byte 5.
  - 1 (NACK): ack_err=1, go to STOP.
- Byte order: {SLAVE_ADDR,1'b0}, y0, y1, speed, trig. A 3-bit byte counter 0..4 drives the sequence.
- STOP (4 quarters): Q0 SCL=0, SDA=0; Q1 SCL=1, SDA=0; Q2-3 SCL=1, SDA=Z.
- GAP: 4 quarters with bus idle. On the last cycle, done=1 for one cycle.
- After GAP:
  - pending=0: busy=0, go to IDLE.
  - pending=1: clear pending, take a fresh snapshot and ack_err clear on that cycle, go straight to START; busy stays 1.
- Full frame = 192 quarters (4 + 5×36 + 4 + 4). A frame NACKed at the address byte = 48 quarters.
- start while busy sets pending. Multiple starts collapse into one pending request. A start on the same cycle pending is consumed is ignored.
- done and a same-cycle start: start counts as a busy-time request (sets pending).

Decomposition:
- Shared package i2c_pkg holds:
  - the FSM state enum;
  - NUM_REGS=4 and FRAME_BYTES=5;
  - the quarter-count function and quarter phase constants Q0..Q3.
- One sub-module, i2c_tick_gen: parameterised quarter-tick counter with sync restart. It outputs a tick pulse and a 2-bit quarter phase.

Test Plan (CLK_HZ=4_000_000, I2C_HZ=100_000 → Q=10 cycles):
- Normal write:
  - Stimulus: y0=8'h40, y1=8'hA0, speed=8'h03, trig=8'h01; start pulse; behavioural slave ACKs every byte.
  - Required: bus bytes 8'h54, 40, A0, 03, 01; done 1920 cycles after launch; ack_err=0. The same frame into the team's I2C slave leaves slv_reg0..3 = 40/A0/03/01.
- Address NACK:
  - Stimulus: slave never ACKs.
  - Required: STOP directly after the 9th bit; ack_err=1; done 480 cycles after launch; ack_err stays 1 until the next launch.
- Queued update:
  - Stimulus: three start pulses during frame 1, inputs changed to 11/22/33/44 before frame 1 ends.
  - Required: exactly one extra frame, carrying 11/22/33/44; busy never drops between the frames; two done pulses in total.
- Snapshot hold:
  - Stimulus: inputs toggle every cycle during a frame.
  - Required: transmitted data equals the values present on the launch cycle.
- Async reset:
  - Stimulus: reset=0 mid-data byte.
  - Required: SCL=1, SDA=Z, busy=0 with no clock edge needed. After release, start yields a clean full frame.
- Protocol checker:
  - Required: SDA never changes while SCL=1 except the START/STOP edges; SCL high and low phases each 20 cycles.
